// File: rtl/jt51_exp_shift_if.sv
// Sample bus for the log-to-linear stage: attenuated input sample in, signed linear sample out.
interface jt51_exp_shift_if #(
  parameter int AW = 13,
  parameter int OW = 14
);
  logic          in_valid;
  logic [AW-1:0] atten;
  logic          sign;
  logic          out_valid;
  logic [OW-1:0] out_dat;

  modport master (output in_valid, atten, sign, input out_valid, out_dat);
  modport slave  (input in_valid, atten, sign, output out_valid, out_dat);
endinterface

// File: rtl/jt51_exp_shift.sv
// Log-to-linear stage: exponent ROM lookup on the attenuation fraction, shift by its integer part, apply sign.
// Optional half-up rounding of the shift when JT51_EXP_ROUND_EN is defined.
module jt51_exp_shift #(
  parameter int AW = 13,
  parameter int MW = 13,
  parameter int OW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  jt51_exp_shift_if.slave io,
  output logic [7:0]    rom_addr,
  input  logic [MW-1:0] rom_data
);
  localparam int STAGES = 3;
  localparam int SW     = AW - 8;

  logic [STAGES:1] vld_pipe;
  logic [AW-1:0]   a_att;
  logic            a_sgn;
  logic [SW-1:0]   b_sh;
  logic            b_sgn;
  logic [MW:0]     sum;
  logic [MW:0]     mag;
  logic [OW-1:0]   dat_nxt;
  logic [OW-1:0]   dat_q;

  // Stage C arithmetic; mag is one bit wider than the ROM so the rounding carry never wraps.
  always_comb begin
    sum = {1'b0, rom_data};
`ifdef JT51_EXP_ROUND_EN
    if (b_sh != '0) sum = sum + ((MW+1)'(1) << (b_sh - SW'(1)));
    mag = (b_sh > SW'(MW)) ? '0 : (sum >> b_sh);
`else
    mag = (b_sh >= SW'(MW)) ? '0 : (sum >> b_sh);
`endif
    dat_nxt = b_sgn ? OW'(-mag) : OW'(mag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      a_att    <= '0;
      a_sgn    <= 1'b0;
      b_sh     <= '0;
      b_sgn    <= 1'b0;
      dat_q    <= '0;
    end else if (cen) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], io.in_valid};
      a_att    <= io.atten;
      a_sgn    <= io.sign;
      b_sh     <= a_att[AW-1:8];
      b_sgn    <= a_sgn;
      // Bubbles still move the datapath, so zero the output explicitly.
      dat_q    <= vld_pipe[STAGES-1] ? dat_nxt : '0;
    end
  end

  assign rom_addr     = a_att[7:0];
  assign io.out_valid = vld_pipe[STAGES];
  assign io.out_dat   = dat_q;
endmodule

// File: tb/tb_jt51_exp_shift.sv
// Directed bench for jt51_exp_shift with a registered exponent ROM model and an expectation queue.
module tb_jt51_exp_shift;
  typedef struct packed {
    logic        vld;
    logic [13:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic [7:0]  rom_addr;
  logic [12:0] rom_data = '0;
  logic [12:0] rom_mem [256];

  exp_t q[$];
  exp_t last;
  int   ncmp  = 0;
  int   nfail = 0;

  jt51_exp_shift_if #(.AW(13), .OW(14)) bus ();

  jt51_exp_shift #(.AW(13), .MW(13), .OW(14)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .io       (bus.slave),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cen) rom_data <= rom_mem[rom_addr];

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [13:0] model(input logic [12:0] a, input logic s);
    int sh = int'(a[12:8]);
    int d  = int'(rom_mem[a[7:0]]);
    int m;
`ifdef JT51_EXP_ROUND_EN
    m = (sh > 13) ? 0 : ((d + ((sh != 0) ? (1 << (sh - 1)) : 0)) >> sh);
`else
    m = (sh >= 13) ? 0 : (d >> sh);
`endif
    return s ? 14'(-m) : 14'(m);
  endfunction

  // One clock: drive at negedge, check just after the posedge.
  task automatic step(input bit c, input bit v, input logic [12:0] a, input bit s, input logic [13:0] e);
    exp_t x;
    @(negedge clk);
    cen = c; bus.in_valid = v; bus.atten = a; bus.sign = s;
    @(posedge clk); #1;
    if (c) begin
      x.vld = v;
      x.dat = v ? e : 14'h0;
      q.push_back(x);
      last = q.pop_front();
      chk("rom_addr", 32'(rom_addr), 32'(a[7:0]));
    end
    chk("out_valid", 32'(bus.out_valid), 32'(last.vld));
    chk("out_dat", 32'(bus.out_dat), 32'(last.dat));
  endtask

  task automatic prime();
    q.delete();
    q.push_back('0);
    q.push_back('0);
    last = '0;
  endtask

  task automatic rand_valid(input int n);
    logic [12:0] a;
    bit s;
    for (int i = 0; i < n; i++) begin
      a = 13'($urandom_range(0, 13'h0CFF));
      s = 1'($urandom_range(0, 1));
      step(1, 1, a, s, model(a, s));
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 13'($urandom_range(0, 8191)), 1'b1, 14'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      rom_mem[i] = 13'($rtoi(8192.0 * $pow(2.0, -real'(i + 1) / 256.0) + 0.5));

    rst_n = 1'b0; cen = 1'b0;
    bus.in_valid = 1'b1; bus.atten = 13'h1234; bus.sign = 1'b1;
    repeat (3) @(negedge clk);
    cen = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_dat", 32'(bus.out_dat), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    cen = 1'b0; rst_n = 1'b1;
    prime();

    step(1, 1, 13'h000, 1'b0, 14'h1FEA);
    step(1, 1, 13'h1FF, 1'b0, 14'h0800);
    step(1, 1, 13'h100, 1'b1, 14'h300B);
`ifdef JT51_EXP_ROUND_EN
    step(1, 1, 13'h301, 1'b0, 14'd1019);
    step(1, 1, 13'hD00, 1'b1, 14'h3FFF);
`else
    step(1, 1, 13'h301, 1'b0, 14'd1018);
    step(1, 1, 13'hD00, 1'b1, 14'h0000);
`endif
    step(1, 1, 13'h1FFF, 1'b1, 14'h0000);
    step(1, 1, 13'hCFF, 1'b0, 14'h0001);
    step(1, 1, 13'hCFF, 1'b1, 14'h3FFF);
    flush(3);

    // Back-to-back stream with a cen gap and a single bubble.
    rand_valid(4);
    step(0, 1, 13'h0AA, 1'b0, 14'h0);
    step(0, 0, 13'h155, 1'b1, 14'h0);
    rand_valid(1);
    step(1, 0, 13'h042, 1'b0, 14'h0);
    rand_valid(2);
    flush(3);

    // Reset while samples are in flight.
    rand_valid(4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.out_valid), 32'd0);
    chk("async_dat", 32'(bus.out_dat), 32'd0);
    chk("async_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    cen = 1'b0; rst_n = 1'b1;
    prime();
    rand_valid(3);
    flush(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/jt51_exp_shift.md
Name: jt51_exp_shift

Overview:
- Log-to-linear conversion stage in the operator datapath.
- Takes a 13-bit log attenuation and a sign, and drives the 8-bit address of the exponent ROM (256x13, registered, cen-qualified, 1-cycle read).
- Shifts the returned 13-bit mantissa right by the integer part of the attenuation and applies the sign, producing a 14-bit two's-complement operator output.
- Fully pipelined: one sample accepted per cen cycle, with a valid flag travelling alongside the data.

Parameters:
- AW, 13, attenuation input width; bits [7:0] are fraction (ROM address), bits [AW-1:8] are integer shift.
- MW, 13, ROM mantissa width.
- OW, 14, signed output width; must be MW+1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only on posedge clk with cen=1
- in_valid  in  1  atten/sign qualify a sample this cen cycle
- atten  in  AW  log attenuation; 0 = loudest
- sign  in  1  1 = negative output
- rom_addr  out  8  exponent ROM address
- rom_data  in  MW  exponent ROM output; valid one cen cycle after rom_addr is presented
- out_valid  out  1  out_dat holds a new sample
- out_dat  out  OW  signed linear result

Behaviour:
- Reset (rst_n low, async): all pipeline registers cleared; rom_addr=0, out_valid=0, out_dat=0. Release is sampled on clk; the first capture happens on the first cen edge after release.
- Stage A (cen edge N): register atten, sign and in_valid as a_att, a_sgn, a_vld. rom_addr = a_att[7:0], driven straight from the register with no combinational path from the inputs.
- ROM (cen edge N+1): the ROM captures rom_addr; rom_data is valid after this edge.
  - Align a_att[AW-1:8] into b_sh (5 bits), a_sgn into b_sgn, a_vld into b_vld on the same edge.
- Stage C (cen edge N+2): compute and register the output.
  - mag = rom_data >> b_sh.
  - If b_sh >= MW, mag = 0.
  - out_dat = b_sgn ? -mag : mag, sign-extended to OW.
  - mag = 0 gives out_dat = 0 regardless of sign; there is no negative zero.
  - out_valid = b_vld.
- Latency: 3 cen edges from input capture to out_valid/out_dat.
- Throughput: 1 sample per cen cycle. There is no backpressure.
- cen low: every register holds, including out_valid. Downstream must qualify out_valid with cen.
- in_valid low: a bubble propagates through the pipeline.
  - Datapath registers still load, so rom_addr follows atten.
  - Stage C forces out_dat=0 when b_vld=0; out_valid=0.
- Range:
  - Maximum magnitude is 0x1FEA (8170), so the output never overflows ±8191.
  - Minimum nonzero occurs at shift 12: 0x1000>>12 = 1.
- Reset mid-stream: in-flight samples are discarded and no partial output is emitted; out_valid stays 0 for 3 cen edges after the first post-reset capture.
- No combinational path from any input to any output.

Optional Feature:
- Macro JT51_EXP_ROUND_EN.
- Defined: stage C rounds half-up, mag = (rom_data + (b_sh ? 1<<(b_sh-1) : 0)) >> b_sh, with a 14-bit intermediate. Shifts >= MW+1 still give 0; shift = MW can round to 1 when rom_data >= 0x1000.
- Undefined: plain truncation as described in Behaviour.
- Latency and interface are identical in both builds.

Test Plan:
- atten=0x000, sign=0, in_valid=1 -> rom_addr=0x00, then 3 cen edges later out_valid=1, out_dat=0x1FEA (8170).
- atten=0x1FF, sign=0 -> rom_addr=0xFF, rom 0x1000 >>1 -> out_dat=0x0800 (2048).
- atten=0x100, sign=1 -> rom 0x1FEA>>1 = 0xFF5 -> out_dat = -4085 = 14'h300B.
- atten=0x301, sign=0 -> rom 0x1FD4>>3 -> out_dat=1018 with macro undefined, 1019 with JT51_EXP_ROUND_EN.
- atten=0xD00 or 0x1FFF, sign=1 -> out_dat=0 (no negative zero).
- Pipeline control, using 4 back-to-back valid samples:
  - Insert a cen=0 gap: outputs hold.
  - Insert one in_valid=0 bubble: exactly one out_valid=0 slot with out_dat=0.
  - Assert rst_n=0 mid-stream: out_valid=0 immediately (async) and no stale sample after release.
